// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the register-file write scheduler: icodes,
// special register IDs, the debug starvation limit and the scheduler state.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE        = 4'hF;
    localparam logic [3:0] RSP          = 4'h4;
    localparam logic [3:0] STARVE_LIMIT = 4'd8;

    typedef enum logic {RUN, HOLD} state_t;
    typedef enum logic {SEL_E, SEL_M} wr_sel_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] addr;
        wr_sel_t    sel;
    } wr_slot_t;

    function automatic logic [63:0] sel_data(input wr_sel_t sel,
                                             input logic [63:0] val_e,
                                             input logic [63:0] val_m);
        return (sel == SEL_M) ? val_m : val_e;
    endfunction

endpackage

// File: rtl/regfile_wr_decode.sv
// Maps a write-back bundle's icode and destinations onto up to two ordered
// register-file write slots; writes aimed at RNONE come out invalid.
module regfile_wr_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] dstE,
    input  logic [3:0] dstM,
    output wr_slot_t   slot0,
    output wr_slot_t   slot1
);

    always_comb begin
        slot0 = '{valid: 1'b0, addr: RNONE, sel: SEL_E};
        slot1 = '{valid: 1'b0, addr: RNONE, sel: SEL_E};
        case (icode)
            IRRMOVQ, IIRMOVQ, IOPQ: slot0 = '{valid: 1'b1, addr: dstE, sel: SEL_E};
            IMRMOVQ:                slot0 = '{valid: 1'b1, addr: dstM, sel: SEL_M};
            ICALL, IRET, IPUSHQ:    slot0 = '{valid: 1'b1, addr: RSP,  sel: SEL_E};
            IPOPQ: begin
                // Stack pointer first, popped value last so it wins when dstM is RSP
                slot0 = '{valid: 1'b1, addr: RSP,  sel: SEL_E};
                slot1 = '{valid: 1'b1, addr: dstM, sel: SEL_M};
            end
            default: ;
        endcase
        slot0.valid = slot0.valid && (slot0.addr != RNONE);
        slot1.valid = slot1.valid && (slot1.addr != RNONE);
    end

endmodule

// File: rtl/regfile_write_sched.sv
// Serialises write-back bundles and debug writes onto a single registered
// register-file write port, holding back the second write of two-write bundles.
module regfile_write_sched
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        W_valid,
    output logic        W_ready,
    input  logic [3:0]  W_icode,
    input  logic [3:0]  W_dstE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valE,
    input  logic [63:0] W_valM,
    input  logic        dbg_req,
    input  logic [3:0]  dbg_addr,
    input  logic [63:0] dbg_data,
    output logic        dbg_gnt,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [63:0] wr_data,
    output logic [31:0] wr_count
);

    state_t      state, state_next;
    wr_slot_t    slot0, slot1;
    logic [3:0]  starve_cnt;
    logic [3:0]  pend_addr;
    logic [63:0] pend_data;
    logic        bundle_writes;
    logic        starved;
    logic        issue_en;
    logic [3:0]  issue_addr;
    logic [63:0] issue_data;
    logic        latch_pend;

    regfile_wr_decode u_decode (
        .icode (W_icode),
        .dstE  (W_dstE),
        .dstM  (W_dstM),
        .slot0 (slot0),
        .slot1 (slot1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (latch_pend) state_next = HOLD;
            HOLD:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Debug wins when the bundle has nothing to write, or once it has starved long enough
    always_comb begin
        bundle_writes = W_valid && (slot0.valid || slot1.valid);
        starved       = (starve_cnt == STARVE_LIMIT);
        dbg_gnt       = 1'b0;
        W_ready       = 1'b0;
        issue_en      = 1'b0;
        issue_addr    = '0;
        issue_data    = '0;
        latch_pend    = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    dbg_gnt = dbg_req && (!bundle_writes || starved);
                    W_ready = !(dbg_gnt && bundle_writes);
                    if (dbg_gnt) begin
                        issue_en   = (dbg_addr != RNONE);
                        issue_addr = dbg_addr;
                        issue_data = dbg_data;
                    end else if (W_valid && slot0.valid) begin
                        issue_en   = 1'b1;
                        issue_addr = slot0.addr;
                        issue_data = sel_data(slot0.sel, W_valE, W_valM);
                        latch_pend = slot1.valid;
                    end else if (W_valid && slot1.valid) begin
                        issue_en   = 1'b1;
                        issue_addr = slot1.addr;
                        issue_data = sel_data(slot1.sel, W_valE, W_valM);
                    end
                end
                HOLD: begin
                    issue_en   = 1'b1;
                    issue_addr = pend_addr;
                    issue_data = pend_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_count   <= '0;
            starve_cnt <= '0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else begin
            wr_en    <= issue_en;
            wr_count <= wr_count + {31'd0, issue_en};
            if (issue_en) begin
                wr_addr <= issue_addr;
                wr_data <= issue_data;
            end
            if (latch_pend) begin
                pend_addr <= slot1.addr;
                pend_data <= sel_data(slot1.sel, W_valE, W_valM);
            end
            if (!dbg_req || dbg_gnt) starve_cnt <= '0;
            else if (!starved)       starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed self-checking bench for regfile_write_sched: reset, decode paths,
// two-write hold, debug starvation and reset during a pending write.
module tb_regfile_write_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        W_valid;
    logic        W_ready;
    logic [3:0]  W_icode;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic        dbg_req;
    logic [3:0]  dbg_addr;
    logic [63:0] dbg_data;
    logic        dbg_gnt;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [63:0] wr_data;
    logic [31:0] wr_count;

    int compared   = 0;
    int mismatched = 0;

    regfile_write_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .W_valid  (W_valid),
        .W_ready  (W_ready),
        .W_icode  (W_icode),
        .W_dstE   (W_dstE),
        .W_dstM   (W_dstM),
        .W_valE   (W_valE),
        .W_valM   (W_valM),
        .dbg_req  (dbg_req),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .dbg_gnt  (dbg_gnt),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] icode,
                                 input logic [3:0] dst_e, input logic [3:0] dst_m,
                                 input logic [63:0] val_e, input logic [63:0] val_m);
        W_valid = valid;
        W_icode = icode;
        W_dstE  = dst_e;
        W_dstM  = dst_m;
        W_valE  = val_e;
        W_valM  = val_m;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkWrite(input string tag, input logic en, input logic [3:0] addr,
                              input logic [63:0] data, input logic [31:0] count);
        checkOutput({tag, ".wr_en"},    64'(wr_en),    64'(en));
        checkOutput({tag, ".wr_addr"},  64'(wr_addr),  64'(addr));
        checkOutput({tag, ".wr_data"},  wr_data,       data);
        checkOutput({tag, ".wr_count"}, 64'(wr_count), 64'(count));
    endtask

    initial begin
        rst_n    = 1'b0;
        dbg_req  = 1'b1;
        dbg_addr = 4'h1;
        dbg_data = 64'h1;
        applyStimulus(1'b1, 4'h6, 4'h3, 4'hF, 64'h11, 64'h0);
        tick();
        tick();
        checkOutput("rst.W_ready", 64'(W_ready), 64'd0);
        checkOutput("rst.dbg_gnt", 64'(dbg_gnt), 64'd0);
        checkWrite("rst", 1'b0, 4'h0, 64'h0, 32'd0);

        // Leave reset idle
        dbg_req = 1'b0;
        applyStimulus(1'b0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("run.W_ready", 64'(W_ready), 64'd1);

        // OPq dstE=3
        applyStimulus(1'b1, 4'h6, 4'h3, 4'hF, 64'h55, 64'h0);
        checkOutput("opq.W_ready", 64'(W_ready), 64'd1);
        tick();
        applyStimulus(1'b1, 4'h7, 4'h3, 4'h3, 64'h99, 64'h98);
        checkWrite("opq", 1'b1, 4'h3, 64'h55, 32'd1);

        // jXX has no writes: accepted, port idle, address/data hold
        checkOutput("jxx.W_ready", 64'(W_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
        checkWrite("jxx", 1'b0, 4'h3, 64'h55, 32'd1);

        // popq dstM=7, with an OPq queued right behind it
        applyStimulus(1'b1, 4'hB, 4'hF, 4'h7, 64'h100, 64'hAB);
        tick();
        applyStimulus(1'b1, 4'h6, 4'h2, 4'hF, 64'h77, 64'h0);
        checkOutput("popq.hold.W_ready", 64'(W_ready), 64'd0);
        checkWrite("popq.e", 1'b1, 4'h4, 64'h100, 32'd2);
        tick();
        checkWrite("popq.m", 1'b1, 4'h7, 64'hAB, 32'd3);
        checkOutput("popq.next.W_ready", 64'(W_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
        checkWrite("popq.next", 1'b1, 4'h2, 64'h77, 32'd4);

        // popq with dstE=dstM=RSP: valE then valM to reg 4
        applyStimulus(1'b1, 4'hB, 4'h4, 4'h4, 64'h100, 64'h200);
        tick();
        applyStimulus(1'b0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
        checkWrite("poprsp.e", 1'b1, 4'h4, 64'h100, 32'd5);
        tick();
        checkWrite("poprsp.m", 1'b1, 4'h4, 64'h200, 32'd6);

        // Debug request starved by back-to-back OPq until the ninth waiting cycle
        dbg_req  = 1'b1;
        dbg_addr = 4'h9;
        dbg_data = 64'hDEAD;
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(1'b1, 4'h6, 4'h1, 4'hF, 64'(k), 64'h0);
            checkOutput($sformatf("starve%0d.dbg_gnt", k), 64'(dbg_gnt), 64'(k == 9));
            checkOutput($sformatf("starve%0d.W_ready", k), 64'(W_ready), 64'(k != 9));
            tick();
            if (k != 9)
                checkWrite($sformatf("starve%0d", k), 1'b1, 4'h1, 64'(k), 32'(6 + k));
        end
        checkWrite("starve.dbg", 1'b1, 4'h9, 64'hDEAD, 32'd15);

        // cmovxx to RNONE does not block the debug request
        dbg_addr = 4'h5;
        dbg_data = 64'h1234;
        applyStimulus(1'b1, 4'h2, 4'hF, 4'hF, 64'hBAD, 64'h0);
        checkOutput("cmov.dbg_gnt", 64'(dbg_gnt), 64'd1);
        checkOutput("cmov.W_ready", 64'(W_ready), 64'd1);
        tick();
        dbg_req = 1'b0;
        applyStimulus(1'b1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
        checkWrite("cmov.dbg", 1'b1, 4'h5, 64'h1234, 32'd16);
        tick();
        applyStimulus(1'b0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
        checkWrite("nop", 1'b0, 4'h5, 64'h1234, 32'd16);

        // Reset while holding popq's M write: it must never appear
        applyStimulus(1'b1, 4'hB, 4'hF, 4'h7, 64'h300, 64'h400);
        tick();
        applyStimulus(1'b0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
        checkWrite("rsthold.e", 1'b1, 4'h4, 64'h300, 32'd17);
        checkOutput("rsthold.W_ready", 64'(W_ready), 64'd0);
        rst_n = 1'b0;
        tick();
        checkWrite("rsthold.rst", 1'b0, 4'h0, 64'h0, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rsthold.run.W_ready", 64'(W_ready), 64'd1);
        tick();
        checkWrite("rsthold.after", 1'b0, 4'h0, 64'h0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_write_sched.md
REGFILE_WRITE_SCHED -- requirements
Module: regfile_write_sched

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset, named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 W_valid  input  1  write-back bundle present.
REQ-005 W_ready  output  1  bundle accepted this cycle when W_valid&&W_ready.
REQ-006 W_icode  input  4  Y86 icode of bundle.
REQ-007 W_dstE, W_dstM  input  4 each  destination register IDs; 4'hF = RNONE.
REQ-008 W_valE, W_valM  input  64 each  write data.
REQ-009 dbg_req  input  1  debug/config write request, held until granted.
REQ-010 dbg_addr  input  4 and dbg_data  input  64  debug write target and data.
REQ-011 dbg_gnt  output  1  combinational grant; the write issues next cycle.
REQ-012 wr_en  output  1, wr_addr  output  4, wr_data  output  64  registered single register-file write port.
REQ-013 wr_count  output  32  registered count of issued writes, wrapping at 2^32.

Function
REQ-014 Decode: icode 2, 3, 6 SHALL produce write E to dstE; icode 5 produces M to dstM; icode 8, 9, A produce E to reg 4; icode B produces E to reg 4 then M to dstM; all other icodes produce no write.
REQ-015 Any write whose address is 4'hF SHALL be dropped; wr_en SHALL never assert with wr_addr=4'hF.
REQ-016 The block SHALL use states RUN and HOLD.
REQ-017 RUN: W_ready=1, except during a forced-debug cycle (REQ-021).
REQ-018 RUN, bundle accepted with one write: that write SHALL be on wr_* the next cycle; the block stays in RUN.
REQ-019 RUN, bundle accepted with two writes: E SHALL issue the next cycle and M SHALL be latched; the block enters HOLD.
REQ-020 HOLD: W_ready=0 and dbg_gnt=0; the latched M SHALL issue the next cycle; the block returns to RUN.
REQ-021 dbg_gnt=dbg_req && state==RUN && (no accepted bundle has a write this cycle, or starve_cnt==STARVE_LIMIT); when forced, W_ready SHALL be 0 for that cycle.
REQ-022 starve_cnt (4 bit) SHALL increment each cycle dbg_req=1 && dbg_gnt=0, saturate at STARVE_LIMIT=8, and clear on grant or when dbg_req=0.
REQ-023 A bundle with zero writes SHALL be accepted in RUN with no wr_en, and SHALL not block dbg_gnt.
REQ-024 popq with dstE==dstM==4 SHALL issue both writes; M last, so the final value of reg 4 is valM.
REQ-025 wr_en SHALL be 0 in any cycle with nothing issued; wr_addr and wr_data then hold their last values.
REQ-026 wr_count SHALL increment by 1 for every wr_en=1 cycle.
REQ-027 Throughput SHALL be one single-write bundle per cycle, and one two-write bundle per two cycles.

Reset
REQ-028 On rst_n=0 at a clock edge: state=RUN, wr_en=0, wr_addr=0, wr_data=0, wr_count=0, starve_cnt=0, and the latched M write is discarded.
REQ-029 During reset, W_ready=0 and dbg_gnt=0; reset asserted in HOLD SHALL never issue the pending M.

Structure
REQ-030 Shared package y86_pkg SHALL hold: icode constants, RNONE=4'hF, RSP=4'h4, STARVE_LIMIT=8, and the state enum.
REQ-031 A combinational sub-module regfile_wr_decode SHALL map {icode, dstE, dstM} to two write slots {valid, addr, sel}, with REQ-015 already applied.

Verification
REQ-032 OPq, dstE=3, valE=0x55, accepted at cycle t -> wr_en=1, wr_addr=3, wr_data=0x55 at t+1; wr_count=1.
REQ-033 popq, dstM=7, valE=0x100, valM=0xAB -> reg 4=0x100 at t+1, reg 7=0xAB at t+2; W_ready=0 at t+1; the next bundle is accepted at t+2.
REQ-034 popq with dstE=dstM=4, valE=0x100, valM=0x200 -> writes to reg 4 are 0x100 then 0x200.
REQ-035 Back-to-back OPq bundles every cycle with dbg_req held -> dbg_gnt=1 on the 9th cycle of waiting, W_ready=0 that cycle, and the debug write appears the next cycle.
REQ-036 cmovxx with dstE=F, then nop, with dbg_req=1 -> no wr_en for the cmovxx; dbg_gnt=1 in the cycle the cmovxx is accepted.
REQ-037 popq accepted, then rst_n=0 in HOLD -> the M write never appears; outputs equal their reset values; the block is in RUN after reset.
